seg_frame_shifter: RTL and testbench
====================================

// Module: seg_frame_shifter
// PURPOSE
//   Downstream stage of the score display path. Takes a 64-bit 7-seg frame (8 digits x 8 segment bits)
//   and shifts it bit-serially into the SWORD board's 74HC164 display chain on SEGCLK/SEGDT.
//   Adds a load/busy/done handshake and a programmable serial-clock divider, so score logic can update at any time.
// PARAMETERS
//   FRAME_W  64  bits per frame; fixed at 64 for the SWORD chain, kept for reuse/tests
//   CLK_DIV  4   clk cycles per SEGCLK phase (low or high); legal >= 1
// PORTS
//   clk     in   1   system clock, all logic on rising edge
//   rst     in   1   asynchronous, active-low reset
//   num     in   64  frame; bit 63 = leftmost digit seg a..dp, bit 0 = rightmost digit dp
//   load    in   1   1-cycle request to send num
//   busy    out  1   high while a frame is being shifted
//   done    out  1   1-cycle pulse when the last bit has been clocked in
//   SEGCLK  out  1   serial clock to the chain; data sampled by the chain on its rising edge
//   SEGCLR  out  1   chain clear, active-low
//   SEGDT   out  1   serial data
//   SEGEN   out  1   display output enable, active-high
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, busy=0, done=0, SEGCLK=0, SEGDT=0, SEGCLR=0, SEGEN=0, pending=0, bit_cnt=0.
//   First clk edge after reset release: SEGCLR=1, held until next reset.
//   FSM: IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | FINISH) -> IDLE.
//   IDLE: load=1 at edge N captures num into shift reg, bit_cnt=0; from cycle N+1 state SHIFT_LO, busy=1.
//   SHIFT_LO: SEGCLK=0, SEGDT=shreg[63], held CLK_DIV cycles, then SHIFT_HI.
//   SHIFT_HI: SEGCLK=1, SEGDT unchanged, held CLK_DIV cycles; at exit shreg<<=1, bit_cnt++.
//     bit_cnt reaching FRAME_W-1 at exit goes to FINISH, else SHIFT_LO. MSB first.
//   FINISH (1 cycle): SEGCLK=0, busy=0, done=1, SEGEN=1 (stays 1 until reset).
//   Latency: load at cycle N -> done at cycle N+1+2*CLK_DIV*FRAME_W; bit k rises SEGCLK at N+1+(2k+1)*CLK_DIV.
//   load while busy: not dropped; sets pending=1. FINISH with pending=1 recaptures current num.
//     It clears pending and enters SHIFT_LO next cycle with no IDLE cycle. Multiple loads while busy collapse to one.
//   load in the FINISH cycle: same as pending.
//   num changes mid-frame: no effect on the frame in flight (shift reg is the only source).
//   Divider counter is 0..CLK_DIV-1; wrap marks the phase change. CLK_DIV=1 gives SEGCLK = clk/2.
//   Reset mid-frame: immediate return to reset values; the chain is cleared via SEGCLR=0.
// CONFIGURATION
//   SEG_AUTO_REFRESH_EN defined:
//     - block holds last_sent[63:0] (reset 0).
//     - in IDLE, num != last_sent starts a frame exactly as a load would.
//     - last_sent is updated at capture.
//     - load still works and forces a resend of identical data.
//   SEG_AUTO_REFRESH_EN undefined: frames are sent only on load/pending; no last_sent register.
// STRUCTURE
//   Package seg_pkg:
//     - state enum {IDLE, SHIFT_LO, SHIFT_HI, FINISH}
//     - SEG_FRAME_W=64, SEG_BLANK_DIGIT=8'hFF
//     - 8-bit segment constants shared with the score display text
//   Sub-module seg_phase_tick: CLK_DIV counter with clear input, outputs 1-cycle tick at wrap.
//   Top holds the FSM, shift reg, bit_cnt, pending flag and output registers.
//   All outputs are registered: no glitches on SEGCLK/SEGDT.
// TESTING
//   Bench models a 64-bit shift register clocked on SEGCLK rising and compares it to the sent frame.
//   1. CLK_DIV=2, num=64'h8000_0000_0000_0001, load at cycle 10:
//        SEGDT=1 for bit 0, 0 for bits 1..62, 1 for bit 63; done at cycle 267; model==num; SEGEN=1.
//   2. Reset: SEGCLR=0, all outputs 0; one cycle after release SEGCLR=1, busy=0, no SEGCLK edges without load.
//   3. Pending: load num=A, then loads with num=B at bit 5 and C at bit 40:
//        exactly two frames A then C; second frame's SHIFT_LO directly follows FINISH.
//   4. Reset mid-frame at bit 30: outputs return to reset values asynchronously.
//        A following load sends the full 64 bits with bit_cnt restarting at 0.
//   5. CLK_DIV=1: SEGCLK period = 2 clk cycles; done at load+129 cycles; model matches 64'h0123_4567_89AB_CDEF.
//   6. SEG_AUTO_REFRESH_EN: num changes 0->64'h55 with no load -> one frame sent.
//        num held -> no further SEGCLK edges; load -> identical frame resent.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment frame path: FSM states, frame width and
// active-low segment encodings (bit 7 = seg a ... bit 0 = dp).
package seg_pkg;

  localparam int unsigned SEG_FRAME_W     = 64;
  localparam logic [7:0]  SEG_BLANK_DIGIT = 8'hFF;
  localparam logic [7:0]  SEG_CHAR_DASH   = 8'hFD;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    FINISH
  } seg_state_e;

  // Hex-free decimal digit encoder used by the score text; anything else renders blank.
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h03;
      4'd1:    s = 8'h9F;
      4'd2:    s = 8'h25;
      4'd3:    s = 8'h0D;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h49;
      4'd6:    s = 8'h41;
      4'd7:    s = 8'h1F;
      4'd8:    s = 8'h01;
      4'd9:    s = 8'h09;
      default: s = SEG_BLANK_DIGIT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_frame_shifter_if.sv
// Request/status bundle between the score logic (master) and the frame shifter (slave).
interface seg_frame_shifter_if
  import seg_pkg::*;
#(
  parameter int unsigned FRAME_W = SEG_FRAME_W
);

  logic [FRAME_W-1:0] num;
  logic               load;
  logic               busy;
  logic               done;

  modport master (output num, output load, input busy, input done);
  modport slave  (input num, input load, output busy, output done);

endinterface

// File: rtl/seg_phase_tick.sv
// Serial-clock phase divider: counts 0..CLK_DIV-1 and pulses tick_o on the wrap cycle.
module seg_phase_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_frame_shifter.sv
// Shifts a 64-bit 7-seg frame MSB-first into a 74HC164 chain with a load/busy/done handshake.
// Optional build macro SEG_AUTO_REFRESH_EN: resend automatically whenever num differs from last frame.
module seg_frame_shifter
  import seg_pkg::*;
#(
  parameter int unsigned FRAME_W = SEG_FRAME_W,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  seg_frame_shifter_if.slave  bus,
  output logic                SEGCLK,
  output logic                SEGCLR,
  output logic                SEGDT,
  output logic                SEGEN
);

  localparam int unsigned BitW = $clog2(FRAME_W);

  seg_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic               pending_q, pending_d;
  logic               segclk_q, segclr_q, segdt_q, segen_q, busy_q, done_q;
  logic               segdt_d, segen_d;
  logic               tick, phase_clr, start, capture;

`ifdef SEG_AUTO_REFRESH_EN
  logic [FRAME_W-1:0] last_sent_q, last_sent_d;
  assign start = bus.load || (bus.num != last_sent_q);
`else
  assign start = bus.load;
`endif

  assign phase_clr = !(state_q == SHIFT_LO || state_q == SHIFT_HI);

  seg_phase_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_tick (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (phase_clr),
    .tick_o(tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    pending_d = pending_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (bus.load) pending_d = 1'b1;
        if (tick) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (bus.load) pending_d = 1'b1;
        if (tick) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == BitW'(FRAME_W - 1)) ? FINISH : SHIFT_LO;
        end
      end
      FINISH: begin
        // Back-to-back frame: no IDLE gap when a request arrived during the last one.
        if (pending_q || bus.load) begin
          capture   = 1'b1;
          pending_d = 1'b0;
          state_d   = SHIFT_LO;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      shreg_d   = bus.num;
      bit_cnt_d = '0;
    end
  end

`ifdef SEG_AUTO_REFRESH_EN
  assign last_sent_d = capture ? bus.num : last_sent_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_sent_q <= '0;
    else      last_sent_q <= last_sent_d;
  end
`endif

  // Outputs are decoded from the next state so every pin comes straight from a flop.
  assign segdt_d = (state_d == SHIFT_LO) ? shreg_d[FRAME_W-1] : segdt_q;
  assign segen_d = segen_q || (state_d == FINISH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      pending_q <= 1'b0;
      segclk_q  <= 1'b0;
      segclr_q  <= 1'b0;
      segdt_q   <= 1'b0;
      segen_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      segclk_q  <= (state_d == SHIFT_HI);
      segclr_q  <= 1'b1;
      segdt_q   <= segdt_d;
      segen_q   <= segen_d;
      busy_q    <= (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
      done_q    <= (state_d == FINISH);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign SEGCLK   = segclk_q;
  assign SEGCLR   = segclr_q;
  assign SEGDT    = segdt_q;
  assign SEGEN    = segen_q;

endmodule

// File: tb/tb_seg_frame_shifter.sv
// Scoreboard bench: two shifters (CLK_DIV=2 and 1) feed 64-bit chain models; done pulses pop
// expected frames and completion cycles from per-DUT queues.
module tb_seg_frame_shifter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  seg_frame_shifter_if bus2 ();
  seg_frame_shifter_if bus1 ();
  logic segclk2, segclr2, segdt2, segen2;
  logic segclk1, segclr1, segdt1, segen1;

  seg_frame_shifter #(.FRAME_W(64), .CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst_n), .bus(bus2),
    .SEGCLK(segclk2), .SEGCLR(segclr2), .SEGDT(segdt2), .SEGEN(segen2)
  );

  seg_frame_shifter #(.FRAME_W(64), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst_n), .bus(bus1),
    .SEGCLK(segclk1), .SEGCLR(segclr1), .SEGDT(segdt1), .SEGEN(segen1)
  );

  typedef struct {
    logic [63:0] frame;
    int          due;
  } exp_t;

  exp_t        q2[$];
  exp_t        q1[$];
  logic [63:0] model2 = '0;
  logic [63:0] model1 = '0;
  int          nbits2 = 0, nbits1 = 0, nedges2 = 0;
  time         last_rise1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int budget);
    n_vec++;
    n_err++;
    $display("FAIL %s: not reached within %0d cycles", name, budget);
  endtask

  always @(posedge segclk2) begin
    model2 = {model2[62:0], segdt2};
    nbits2++;
    nedges2++;
  end

  always @(posedge segclk1) begin
    if (nbits1 > 0) check("segclk1_period", 64'($time - last_rise1), 64'd20);
    last_rise1 = $time;
    model1 = {model1[62:0], segdt1};
    nbits1++;
  end

  task automatic done_seen(input int d);
    exp_t e;
    n_vec++;
    if ((d == 0 && q2.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_err++;
      $display("FAIL dut%0d_unexpected_frame: done at cycle %0d, expected no frame", 2 - d, cyc);
    end else if (d == 0) begin
      e = q2.pop_front();
      check("dut2_frame", model2, e.frame);
      check("dut2_bits", 64'(nbits2), 64'd64);
      check("dut2_done_cycle", 64'(cyc), 64'(e.due));
      check("dut2_busy_at_done", bus2.busy, 1'b0);
    end else begin
      e = q1.pop_front();
      check("dut1_frame", model1, e.frame);
      check("dut1_bits", 64'(nbits1), 64'd64);
      check("dut1_done_cycle", 64'(cyc), 64'(e.due));
    end
    if (d == 0) nbits2 = 0;
    else        nbits1 = 0;
  endtask

  always @(negedge clk) begin
    if (bus2.done) done_seen(0);
    if (bus1.done) done_seen(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input logic [63:0] v);
    if (d == 0) begin
      bus2.num = v; bus2.load = 1'b1;
    end else begin
      bus1.num = v; bus1.load = 1'b1;
    end
    tick(1);
    bus2.load = 1'b0;
    bus1.load = 1'b0;
  endtask

  task automatic wait_empty(input int d, input int budget);
    int k = 0;
    while (((d == 0) ? q2.size() : q1.size()) != 0 && k < budget) begin
      tick(1);
      k++;
    end
    if (((d == 0) ? q2.size() : q1.size()) != 0) timeout("frame_complete", budget);
  endtask

  task automatic wait_bits(input int n, input int budget);
    int k = 0;
    while (nbits2 < n && k < budget) begin
      tick(1);
      k++;
    end
    if (nbits2 < n) timeout("bit_position", budget);
  endtask

  task automatic check_reset_outputs();
    check("rst_segclk", segclk2, 1'b0);
    check("rst_segclr", segclr2, 1'b0);
    check("rst_segdt", segdt2, 1'b0);
    check("rst_segen", segen2, 1'b0);
    check("rst_busy", bus2.busy, 1'b0);
    check("rst_done", bus2.done, 1'b0);
  endtask

  int p;
  int e0;

  initial begin
    bus2.num = '0; bus2.load = 1'b0;
    bus1.num = '0; bus1.load = 1'b0;

    // Reset values, then SEGCLR rises on the first edge after release.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    check("rst_segclr_dut1", segclr1, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("segclr_after_release", segclr2, 1'b1);
    check("busy_after_release", bus2.busy, 1'b0);
    check("segclr_after_release_dut1", segclr1, 1'b1);
    while (cyc < 10) tick(1);
    check("no_segclk_without_load", 64'(nedges2), 64'd0);

    // Single frame, load at cycle 10, done at 267.
    q2.push_back('{64'h8000_0000_0000_0001, 267});
    send(0, 64'h8000_0000_0000_0001);
    wait_empty(0, 400);
    check("segen_after_frame", segen2, 1'b1);

    // Pending: B and C during frame A collapse into one C frame right after A.
    tick(3);
    e0 = nedges2;
    p  = cyc;
    q2.push_back('{64'hA5A5_0F0F_1234_5678, p + 257});
    send(0, 64'hA5A5_0F0F_1234_5678);
    wait_bits(5, 100);
    send(0, 64'hBBBB_BBBB_BBBB_BBBB);
    wait_bits(40, 400);
    q2.push_back('{64'hC3C3_C3C3_0000_FFFF, p + 514});
    send(0, 64'hC3C3_C3C3_0000_FFFF);
    wait_empty(0, 800);
    tick(20);
    check("pending_total_edges", 64'(nedges2 - e0), 64'd128);

    // Reset in the middle of a frame, then a clean full frame.
    tick(3);
    p = cyc;
    q2.push_back('{64'hDEAD_BEEF_CAFE_F00D, p + 257});
    send(0, 64'hDEAD_BEEF_CAFE_F00D);
    wait_bits(30, 300);
    rst_n = 1'b0;
    bus2.num = '0;
    #1 check_reset_outputs();
    void'(q2.pop_back());
    model2 = '0;
    nbits2 = 0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    p = cyc;
    q2.push_back('{64'hFEDC_BA98_7654_3210, p + 257});
    send(0, 64'hFEDC_BA98_7654_3210);
    wait_empty(0, 400);

    // CLK_DIV=1: SEGCLK = clk/2, done 129 cycles after load.
    tick(2);
    p = cyc;
    q1.push_back('{64'h0123_4567_89AB_CDEF, p + 129});
    send(1, 64'h0123_4567_89AB_CDEF);
    wait_empty(1, 300);

    // num change without load, then a load of identical data.
    tick(2);
`ifdef SEG_AUTO_REFRESH_EN
    p = cyc;
    q2.push_back('{64'h55, p + 257});
    bus2.num = 64'h55;
    tick(1);
    wait_empty(0, 400);
    e0 = nedges2;
    tick(50);
    check("no_resend_when_held", 64'(nedges2 - e0), 64'd0);
`else
    e0 = nedges2;
    bus2.num = 64'h55;
    tick(50);
    check("no_frame_without_load", 64'(nedges2 - e0), 64'd0);
`endif
    p = cyc;
    q2.push_back('{64'h55, p + 257});
    send(0, 64'h55);
    wait_empty(0, 400);
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
